add_seq_wide: RTL and testbench
===============================

# add_seq_wide

Multi-precision add/subtract sequencer. It accepts two `16*WORDS`-bit operands over a valid/ready handshake and computes the result one 16-bit slice per cycle, least-significant first, on a single 16-bit carry-chained adder datapath. The carry is held in a register between slices. This is the block that shares one `Adder16`-class slice across wide arithmetic in the GPC datapath, so that no `16*WORDS`-bit adder is needed.

## Interface
Parameters:
- `WORDS`, default 4: number of 16-bit slices; operand width is `16*WORDS`; legal values are ≥1.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: block can accept a request.
- `sub`, input, 1: 0 computes `a+b`; 1 computes `a-b`.
- `a`, input, `16*WORDS`: operand A, unsigned or two's complement.
- `b`, input, `16*WORDS`: operand B.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: consumer takes the result.
- `sum`, output, `16*WORDS`: result.
- `cout`, output, 1: carry out of the MSB; for subtract, 1 means no borrow.
- `ovf`, output, 1: signed two's-complement overflow.

## Operation
- States: `IDLE`, `RUN`, `DONE`. Encoding is free.
- `in_ready` is 1 exactly when the state is `IDLE`. `out_valid` is 1 exactly when the state is `DONE`.
- **`IDLE`:**
  - On `in_valid & in_ready`, latch `A = a` and `B' = sub ? ~b : b`, and set `carry = sub`.
  - Clear slice index `idx` to 0 and move to `RUN`.
- **`RUN`:** each cycle, the adder computes `{c, s} = A[idx] + B'[idx] + carry`. At the edge:
  - write `sum[idx] = s`;
  - set `carry = c`;
  - when `idx == WORDS-1`, go to `DONE` and register `cout = c`; otherwise increment `idx`.
- **`ovf`:** registered at the last slice as `(A_msb == B'_msb) & (s_msb != A_msb)`.
- **`DONE`:**
  - Hold `sum`, `cout` and `ovf` stable.
  - On `out_ready`, go to `IDLE`.
  - `sum`, `cout` and `ovf` keep their values after the transfer until the next request overwrites them.
- **Ignored inputs:**
  - `in_valid` outside `IDLE` is ignored, and the requester must hold its request.
  - `a`, `b` and `sub` are sampled only on the accept edge, so later changes have no effect.
  - `out_ready` outside `DONE` is ignored.
- **Width and wrap rules:**
  - Results are modulo `2^(16*WORDS)`.
  - `idx` is `max(1, $clog2(WORDS))` bits wide and never wraps beyond `WORDS-1`.
  - With `WORDS=1`, `RUN` lasts exactly one cycle.
- **Reset (`rst_n` low, asynchronous):**
  - State goes to `IDLE`.
  - `idx`, `carry`, `sum`, `cout` and `ovf` go to 0.
  - `in_ready` is therefore 1 and `out_valid` is 0, both during and after reset.
  - Reset mid-`RUN` or mid-`DONE` abandons the operation; no partial result is presented.

## Timing
- Request accepted at edge 0; `RUN` occupies cycles 1..`WORDS`.
- `out_valid` rises in cycle `WORDS+1`, which is 5 for the default.
- Latency from accept edge to `out_valid`: `WORDS+1` cycles.
- When `out_ready` is already high, `DONE` lasts 1 cycle.
- `in_ready` returns in the cycle after the output transfer.
- Minimum accept-to-accept spacing is `WORDS+2` cycles.
- Outputs are registered or state-decoded only; there is no combinational path from any input to any output.

## Test plan
- **Carry through all slices** (`WORDS=4`): `a=0xFFFF_FFFF_FFFF_FFFF`, `b=1`, `sub=0` → `sum=0`, `cout=1`, `ovf=0`, `out_valid` first high 5 cycles after the accept edge.
- **Subtract with borrow:** `a=0`, `b=1`, `sub=1` → `sum=0xFFFF_FFFF_FFFF_FFFF`, `cout=0`, `ovf=0`. Then `a=5`, `b=3`, `sub=1` → `sum=2`, `cout=1`.
- **Signed overflow:**
  - `a=0x7FFF_FFFF_FFFF_FFFF`, `b=1`, add → `sum=0x8000_0000_0000_0000`, `ovf=1`, `cout=0`.
  - `a=0x8000_0000_0000_0000`, `b=1`, sub → `ovf=1`.
- **Backpressure:** hold `out_ready=0` for 10 cycles in `DONE` → `sum`/`cout`/`ovf` stable and `in_ready=0` throughout. A pending `in_valid` with different operands is not accepted and does not corrupt the result. Raise `out_ready` → `in_ready=1` next cycle.
- **Reset mid-operation:** pull `rst_n` low asynchronously in `RUN` cycle 2 (no clock edge needed) → `out_valid=0`, `in_ready=1`, `sum=0` immediately. After release, a fresh request `1+2` yields `sum=3` at the nominal latency.
- **Back-to-back with `out_ready` tied high:** three requests → accepts spaced exactly 6 cycles apart, and each result matches the reference model for random `a`, `b`, `sub`. Repeat the whole check with `WORDS=1`, where spacing is 3.

Source files
------------

// File: rtl/add_seq_wide.sv
// Multi-precision add/subtract sequencer: one shared 16-bit carry-chained adder
// walks the operands least-significant slice first, holding the carry between slices.
module add_seq_wide #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg;
    logic [IW-1:0]   idx_reg;
    logic            carry_reg, cout_reg, ovf_reg;
    logic [15:0]     a_slice, b_slice, s_slice;
    logic            c_slice;
    logic            last_slice;
    logic            accept;

    assign accept     = (state_reg == IDLE) & in_valid;
    assign last_slice = (idx_reg == LAST_IDX);
    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign cout       = cout_reg;
    assign ovf        = ovf_reg;

    // Slice select by comparison keeps the mux legal for WORDS=1 as well.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_reg == IW'(i)) begin
                a_slice = a_reg[i*16 +: 16];
                b_slice = b_reg[i*16 +: 16];
            end
        end
    end

    assign {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {16'd0, carry_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            carry_reg <= c_slice;
            if (last_slice) begin
                cout_reg <= c_slice;
                ovf_reg  <= (a_slice[15] == b_slice[15]) & (s_slice[15] != a_slice[15]);
            end else begin
                idx_reg <= idx_reg + IW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        logic [15:0] word_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if ((state_reg == RUN) && (idx_reg == IW'(gi))) begin
                word_reg <= s_slice;
            end
        end

        assign sum[gi*16 +: 16] = word_reg;
    end

endmodule

// File: tb/tb_add_seq_wide.sv
// Bench for add_seq_wide: WORDS=4 and WORDS=1 instances, randomized operands checked
// against an arithmetic reference model, plus directed carry/borrow/overflow cases.
module tb_add_seq_wide;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, sub = 1'b0;
    logic [63:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b0, cout, ovf;

    logic        in_valid1 = 1'b0, in_ready1, sub1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0, sum1;
    logic        out_valid1, out_ready1 = 1'b0, cout1, ovf1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_seq_wide #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    add_seq_wide #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .sub(sub1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .ovf(ovf1)
    );

    // Returns {ovf, cout, sum} for a w-bit add/subtract using plain integer arithmetic.
    function automatic logic [65:0] ref_model(input logic [63:0] x_in, input logic [63:0] y_in,
                                              input logic s, input int w);
        logic [63:0]        mask, x, y;
        logic [64:0]        tot;
        logic signed [66:0] sx, sy, r, lim;
        logic               c, o;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = x_in & mask;
        y = y_in & mask;
        if (!s) begin
            tot = {1'b0, x} + {1'b0, y};
            c   = tot[w];
        end else begin
            tot = {1'b0, x} - {1'b0, y};
            c   = (x >= y);
        end
        sx = $signed({3'b000, x});
        sy = $signed({3'b000, y});
        if (x[w-1]) sx = sx - (67'sd1 <<< w);
        if (y[w-1]) sy = sy - (67'sd1 <<< w);
        r   = s ? (sx - sy) : (sx + sy);
        lim = 67'sd1 <<< (w - 1);
        o   = (r >= lim) || (r < -lim);
        return {o, c, tot[63:0] & mask};
    endfunction

    // Issue one request to the WORDS=4 instance; lat is the cycle number (accept edge
    // starts cycle 1) in which out_valid is first seen, or -1 on timeout.
    task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic is,
                          output int lat);
        @(negedge clk);
        a = ia; b = ib; sub = is; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ia; b = ~ib; sub = ~is;
        lat = 0;
        repeat (40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if ({ovf, cout, sum} !== 66'd0) $display("FAIL reset_result got %b %b %h want 0 0 0", ovf, cout, sum); else pass_cnt++;
        total_cnt++; if ({in_ready1, out_valid1, sum1} !== {1'b1, 1'b0, 16'd0}) $display("FAIL reset_w1 got rdy=%b vld=%b sum=%h want 1 0 0", in_ready1, out_valid1, sum1); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL post_reset_hs got rdy=%b vld=%b want 1 0", in_ready, out_valid); else pass_cnt++;
    endtask

    task automatic test_carry();
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
        total_cnt++; if (lat != 5) $display("FAIL carry_latency got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if ({ovf, cout, sum} !== {1'b0, 1'b1, 64'h0}) $display("FAIL carry_result got ovf=%b cout=%b sum=%h want 0 1 0", ovf, cout, sum); else pass_cnt++;
        consume();
    endtask

    task automatic test_subtract();
        int lat;
        run_op(64'd0, 64'd1, 1'b1, lat);
        total_cnt++; if ({ovf, cout, sum} !== {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) $display("FAIL sub_borrow got ovf=%b cout=%b sum=%h want 0 0 ffffffffffffffff", ovf, cout, sum); else pass_cnt++;
        consume();
        run_op(64'd5, 64'd3, 1'b1, lat);
        total_cnt++; if ({ovf, cout, sum} !== {1'b0, 1'b1, 64'd2}) $display("FAIL sub_small got ovf=%b cout=%b sum=%h want 0 1 2", ovf, cout, sum); else pass_cnt++;
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
        total_cnt++; if ({ovf, cout, sum} !== {1'b1, 1'b0, 64'h8000_0000_0000_0000}) $display("FAIL ovf_add got ovf=%b cout=%b sum=%h want 1 0 8000000000000000", ovf, cout, sum); else pass_cnt++;
        consume();
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, lat);
        total_cnt++; if ({ovf, cout, sum} !== {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF}) $display("FAIL ovf_sub got ovf=%b cout=%b sum=%h want 1 1 7fffffffffffffff", ovf, cout, sum); else pass_cnt++;
        consume();
    endtask

    task automatic test_random();
        logic [63:0] x, y;
        logic        s;
        logic [65:0] exp;
        int          lat;
        for (int k = 0; k < 8; k++) begin
            x = {$urandom, $urandom};
            y = (k == 3) ? x : {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            exp = ref_model(x, y, s, 64);
            run_op(x, y, s, lat);
            total_cnt++; if (lat != 5) $display("FAIL rand_latency[%0d] got %0d want 5", k, lat); else pass_cnt++;
            total_cnt++; if ({ovf, cout, sum} !== exp) $display("FAIL rand_result[%0d] got %h want %h (a=%h b=%h sub=%b)", k, {ovf, cout, sum}, exp, x, y, s); else pass_cnt++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] x, y;
        logic        s;
        logic [65:0] exp;
        int          lat;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        s = 1'($urandom_range(0, 1));
        exp = ref_model(x, y, s, 64);
        run_op(x, y, s, lat);
        total_cnt++; if ({ovf, cout, sum} !== exp) $display("FAIL bp_result got %h want %h", {ovf, cout, sum}, exp); else pass_cnt++;
        a = ~x; b = y + 64'd7; sub = ~s; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({in_ready, out_valid, ovf, cout, sum} !== {1'b0, 1'b1, exp})
                $display("FAIL bp_hold[%0d] got rdy=%b vld=%b res=%h want 0 1 %h", k, in_ready, out_valid, {ovf, cout, sum}, exp);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); else pass_cnt++;
        total_cnt++; if ({ovf, cout, sum} !== exp) $display("FAIL bp_retain got %h want %h", {ovf, cout, sum}, exp); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0F0F_0F0F_0F0F_0F0F; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL mid_reset_hs got rdy=%b vld=%b want 1 0", in_ready, out_valid); else pass_cnt++;
        total_cnt++; if ({ovf, cout, sum} !== 66'd0) $display("FAIL mid_reset_result got %h want 0", {ovf, cout, sum}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_reset_no_result got vld=%b want 0", out_valid); else pass_cnt++;
        run_op(64'd1, 64'd2, 1'b0, lat);
        total_cnt++; if (lat != 5) $display("FAIL mid_reset_latency got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if ({ovf, cout, sum} !== {1'b0, 1'b0, 64'd3}) $display("FAIL mid_reset_sum got %h want 3", {ovf, cout, sum}); else pass_cnt++;
        consume();
    endtask

    task automatic test_back_to_back();
        logic [65:0] exp;
        int          acc, prev, n;
        out_ready = 1'b1;
        prev = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom_range(0, 1));
            exp = ref_model(a, b, sub, 64);
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk);
            #1;
            acc = cyc;
            if (k == 2) in_valid = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 20);
            total_cnt++; if ({ovf, cout, sum} !== exp || !out_valid) $display("FAIL b2b_result[%0d] got vld=%b res=%h want %h", k, out_valid, {ovf, cout, sum}, exp); else pass_cnt++;
            if (k > 0) begin
                total_cnt++; if (acc - prev != 6) $display("FAIL b2b_spacing[%0d] got %0d want 6", k, acc - prev); else pass_cnt++;
            end
            prev = acc;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back_w1();
        logic [65:0] exp;
        int          acc, prev, n;
        out_ready1 = 1'b1;
        prev = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            a1 = 16'($urandom); b1 = 16'($urandom); sub1 = 1'($urandom_range(0, 1));
            exp = ref_model({48'd0, a1}, {48'd0, b1}, sub1, 16);
            in_valid1 = 1'b1;
            n = 0;
            while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
            @(posedge clk);
            #1;
            acc = cyc;
            if (k == 2) in_valid1 = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid1 && n < 20);
            total_cnt++; if ({ovf1, cout1, sum1} !== {exp[65:64], exp[15:0]} || !out_valid1) $display("FAIL w1_result[%0d] got vld=%b res=%h want %h", k, out_valid1, {ovf1, cout1, sum1}, {exp[65:64], exp[15:0]}); else pass_cnt++;
            if (k > 0) begin
                total_cnt++; if (acc - prev != 3) $display("FAIL w1_spacing[%0d] got %0d want 3", k, acc - prev); else pass_cnt++;
            end
            prev = acc;
        end
        out_ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry();
        test_subtract();
        test_overflow();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_back_to_back_w1();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
